// File: rtl/modport_counter.sv
// Loadable WIDTH-bit up/down counter; registered output, one-cycle latency, no backpressure.
// Define MODPORT_COUNTER_SAT_EN to saturate at 0 / 2**WIDTH-1 instead of wrapping.
module modport_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_down,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

`ifdef MODPORT_COUNTER_SAT_EN
  // Hold at the rails rather than rolling over.
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
  assign count_dec = (count_q == CNT_MIN) ? count_q : count_q - CNT_ONE;
`else
  assign count_inc = count_q + CNT_ONE;
  assign count_dec = count_q - CNT_ONE;
`endif

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data_in;
    end else if (up_down) begin
      count_d = count_inc;
    end else begin
      count_d = count_dec;
    end
  end

  // Reset outranks load and counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign data_out = count_q;

endmodule

// File: tb/tb_modport_counter.sv
// Directed bench for modport_counter; expected values hand-computed for both builds.
module tb_modport_counter;

`ifdef MODPORT_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] data_in;
  logic       up_down;
  logic [3:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  modport_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .up_down  (up_down),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; data_in = 4'd9; up_down = 1'b1;
    #2;

    // reset beats load for two cycles
    tick(); check("rst_beats_load_0", data_out, 4'd0);
    tick(); check("rst_beats_load_1", data_out, 4'd0);

    // load 5 then count up 3
    reset = 1'b0; load = 1'b1; data_in = 4'd5; up_down = 1'b0;
    tick(); check("load5", data_out, 4'd5);
    load = 1'b0; up_down = 1'b1;
    tick(); check("up6", data_out, 4'd6);
    tick(); check("up7", data_out, 4'd7);
    tick(); check("up8", data_out, 4'd8);

    // no combinational path: change inputs mid-cycle
    load = 1'b1; data_in = 4'd3; up_down = 1'b0;
    #2; check("no_comb_path", data_out, 4'd8);

    // up across the top
    load = 1'b1; data_in = 4'd14; up_down = 1'b1;
    tick(); check("load14", data_out, 4'd14);
    load = 1'b0;
    tick(); check("up15", data_out, 4'd15);
    tick(); check("up_wrap_top0", data_out, SAT ? 4'd15 : 4'd0);
    tick(); check("up_wrap_top1", data_out, SAT ? 4'd15 : 4'd1);

    // reset then down across the bottom
    reset = 1'b1;
    tick(); check("rst_before_down", data_out, 4'd0);
    reset = 1'b0; up_down = 1'b0;
    tick(); check("down_wrap_bot0", data_out, SAT ? 4'd0 : 4'd15);
    tick(); check("down_wrap_bot1", data_out, SAT ? 4'd0 : 4'd14);

    // count up from 3, load 10 with up_down=0, then count down
    load = 1'b1; data_in = 4'd3; up_down = 1'b1;
    tick(); check("load3", data_out, 4'd3);
    load = 1'b0;
    tick(); check("up4", data_out, 4'd4);
    load = 1'b1; data_in = 4'd10; up_down = 1'b0;
    tick(); check("load10_over_count", data_out, 4'd10);
    load = 1'b0;
    tick(); check("down9", data_out, 4'd9);
    tick(); check("down8", data_out, 4'd8);

    // load ignores up_down toggling
    load = 1'b1; data_in = 4'd2; up_down = 1'b1;
    tick(); check("load2_up", data_out, 4'd2);
    up_down = 1'b0;
    tick(); check("load2_down", data_out, 4'd2);

    // count to 7, reset one cycle, resume up
    data_in = 4'd5; up_down = 1'b1;
    tick(); check("load5_again", data_out, 4'd5);
    load = 1'b0;
    tick(); check("up6_again", data_out, 4'd6);
    tick(); check("up7_again", data_out, 4'd7);
    reset = 1'b1;
    tick(); check("mid_count_rst", data_out, 4'd0);
    reset = 1'b0;
    tick(); check("resume1", data_out, 4'd1);
    tick(); check("resume2", data_out, 4'd2);

    // load the top value and count down normally
    load = 1'b1; data_in = 4'd15; up_down = 1'b1;
    tick(); check("load15", data_out, 4'd15);
    load = 1'b0; up_down = 1'b0;
    tick(); check("down14", data_out, 4'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
